rv_iopmp_err_recorder: RTL



---
 rtl/rv_iopmp_err_recorder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rv_iopmp_err_recorder.sv
// IOPMP error recorder: holds the first pending violation and drives the WSI line.
// Define RV_IOPMP_ERR_DROP_CNT_EN to build the saturating dropped-error counter.
module rv_iopmp_err_recorder #(
   parameter int ADDR_WIDTH          = 64,
   parameter int SID_WIDTH           = 1,
   parameter int NUMBER_TL_INSTANCES = 1,
   localparam int IW = (NUMBER_TL_INSTANCES > 1) ? $clog2(NUMBER_TL_INSTANCES) : 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NUMBER_TL_INSTANCES-1:0]            err_valid_i,
   input  logic [NUMBER_TL_INSTANCES*ADDR_WIDTH-1:0] err_addr_i,
   input  logic [NUMBER_TL_INSTANCES*SID_WIDTH-1:0]  err_sid_i,
   input  logic [NUMBER_TL_INSTANCES*2-1:0]          err_ttype_i,
   input  logic [NUMBER_TL_INSTANCES*3-1:0]          err_etype_i,
   input  logic                                      intr_en_i,
   input  logic                                      clr_i,
   input  logic                                      cnt_clr_i,
   output logic                                      ip_o,
   output logic [ADDR_WIDTH-1:0]                     rec_addr_o,
   output logic [SID_WIDTH-1:0]                      rec_sid_o,
   output logic [1:0]                                rec_ttype_o,
   output logic [2:0]                                rec_etype_o,
   output logic [IW-1:0]                             rec_inst_o,
   output logic [15:0]                               drop_cnt_o,
   output logic                                      wsi_wire_o
);

   localparam int N = NUMBER_TL_INSTANCES;
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] CAPTURED = 1'b1;

   logic [0:0]            state_q;
   logic [IW-1:0]         rr_q;
   logic [IW-1:0]         win;
   logic                  found;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [SID_WIDTH-1:0]  sel_sid;
   logic [1:0]            sel_ttype;
   logic [2:0]            sel_etype;
   logic [IW-1:0]         rr_nxt;
   logic                  capture;

   // Round-robin search starting at rr_q, wrapping past N-1 back to 0.
   always_comb begin
      win       = '0;
      found     = 1'b0;
      sel_addr  = '0;
      sel_sid   = '0;
      sel_ttype = '0;
      sel_etype = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(rr_q) + k) % N;
         if (!found && err_valid_i[idx]) begin
            found     = 1'b1;
            win       = IW'(idx);
            sel_addr  = err_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
            sel_sid   = err_sid_i[idx*SID_WIDTH +: SID_WIDTH];
            sel_ttype = err_ttype_i[idx*2 +: 2];
            sel_etype = err_etype_i[idx*3 +: 3];
         end
      end
   end

   assign rr_nxt  = (win == IW'(N-1)) ? '0 : win + 1'b1;
   assign capture = found && ((state_q == IDLE) || clr_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         rec_addr_o  <= '0;
         rec_sid_o   <= '0;
         rec_ttype_o <= '0;
         rec_etype_o <= '0;
         rec_inst_o  <= '0;
      end else if (capture) begin
         state_q     <= CAPTURED;
         rr_q        <= rr_nxt;
         rec_addr_o  <= sel_addr;
         rec_sid_o   <= sel_sid;
         rec_ttype_o <= sel_ttype;
         rec_etype_o <= sel_etype;
         rec_inst_o  <= win;
      end else if (state_q == CAPTURED && clr_i) begin
         state_q <= IDLE;
      end
   end

   assign ip_o       = (state_q == CAPTURED);
   assign wsi_wire_o = ip_o & intr_en_i;

`ifdef RV_IOPMP_ERR_DROP_CNT_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [31:0] pc;
   logic [31:0] drops;
   logic [32:0] sum;

   // Pending without clear drops everything; otherwise only arbitration losers.
   always_comb begin
      pc = '0;
      for (int k = 0; k < N; k++) begin
         pc = pc + 32'(err_valid_i[k]);
      end
      drops = '0;
      if (state_q == CAPTURED && !clr_i) begin
         drops = pc;
      end else if (found) begin
         drops = pc - 32'd1;
      end
      sum = {17'b0, (cnt_clr_i ? 16'd0 : cnt_q)} + {1'b0, drops};
      cnt_d = (sum > 33'h0FFFF) ? 16'hFFFF : sum[15:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign drop_cnt_o = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign drop_cnt_o     = '0;
`endif

endmodule
